// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with valid/ready byte handoff; TxD, tx_ready and tx_done are flop outputs.
// Optional even-parity bit between data and stop is enabled by defining UART_TX_PARITY_EN.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line high, tx_ready=1, waiting for a byte
// S_START  | start bit (0) for BIT_DIV cycles
// S_DATA   | 8 data bits LSB-first, BIT_DIV cycles each
// S_PARITY | even parity bit (UART_TX_PARITY_EN only)
// S_STOP   | stop bit (1), tx_done pulses on exit
module uart_transmitter #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9_600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TxD,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BIT_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             txd_q, txd_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             bit_end;
    logic             accept;

    assign bit_end  = (cnt_q == CNT_LAST);
    assign accept   = (state_q == S_IDLE) && tx_valid && ready_q;
    assign TxD      = txd_q;
    assign tx_ready = ready_q;
    assign tx_busy  = ~ready_q;
    assign tx_done  = done_q;

`ifdef UART_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (reset)       parity_q <= 1'b0;
        else if (accept) parity_q <= ^tx_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            txd_q    <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            txd_q    <= txd_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    // Outputs are computed for the next state so the flops present them without a cycle of lag.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        txd_d    = txd_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                bitcnt_d = '0;
                txd_d    = 1'b1;
                ready_d  = 1'b1;
                if (accept) begin
                    state_d = S_START;
                    shreg_d = tx_data;
                    txd_d   = 1'b0;
                    ready_d = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    txd_d   = shreg_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    shreg_d  = {1'b0, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        txd_d = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                    txd_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                txd_d   = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

endmodule
